// File: rtl/router_pkg.sv
// Shared router/NoC types: flit layout, node address config, and the packet sink's error mask and states.
package router_pkg;

    localparam int FLIT_SIZE  = 24;
    localparam int TAIL_TAG_W = 16;
    localparam int ADDR_W     = 8;

    // Flit layout: [23] valid, [22:21] type, [15:8] xaddr / [7:0] yaddr on HEAD, [15:0] tag on TAIL
    localparam int FT_MSB   = 22;
    localparam int FT_LSB   = 21;
    localparam int XADDR_LSB = 8;
    localparam int YADDR_LSB = 0;

    typedef struct packed {
        int xaddr;
        int yaddr;
    } ROUTER_CONFIG;

    typedef struct packed {
        logic [FLIT_SIZE-1:0] flit;
    } FLIT_t;

    typedef enum logic [1:0] {
        FT_HEAD = 2'd0,
        FT_BODY = 2'd1,
        FT_TAIL = 2'd2,
        FT_RSVD = 2'd3
    } FLIT_TYPE_t;

    typedef struct packed {
        logic timeout;
        logic seq;
        logic addr;
    } SINK_ERR_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_HEAD = 3'd1,
        S_RECV      = 3'd2,
        S_DRAIN     = 3'd3,
        S_DONE      = 3'd4
    } SINK_STATE_t;

    function automatic FLIT_TYPE_t flit_type(input FLIT_t f);
        return FLIT_TYPE_t'(f.flit[FT_MSB:FT_LSB]);
    endfunction

endpackage

// File: rtl/pkt_latency_tracker.sv
// Free-running 16-bit cycle counter; latency = counter - TAIL tag (mod 2^16), kept as last/max over good packets.
// Latency is captured on the TAIL cycle and committed one cycle later; no backpressure.
module pkt_latency_tracker
    import router_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_tag_vld,
    input  logic [TAIL_TAG_W-1:0] i_tag,
    input  logic                  i_commit,
    output logic [TAIL_TAG_W-1:0] o_last_lat,
    output logic [TAIL_TAG_W-1:0] o_max_lat
);

    logic [TAIL_TAG_W-1:0] cycle_cnt;
    logic [TAIL_TAG_W-1:0] lat_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt  <= '0;
            lat_q      <= '0;
            o_last_lat <= '0;
            o_max_lat  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (i_tag_vld)
                lat_q <= cycle_cnt - i_tag;
            if (i_commit) begin
                o_last_lat <= lat_q;
                if (lat_q > o_max_lat)
                    o_max_lat <= lat_q;
            end
        end
    end

endmodule

// File: rtl/packet_sink.sv
// Router-ejection packet checker: validates HEAD/BODY*/TAIL structure and address, counts good/bad packets.
// One DONE cycle per packet, then IDLE; flits are accepted only while o_rec_ack is high (no stall of the router).
// PKT_SINK_LAT_EN adds latency tracking from the TAIL tag; otherwise o_last_lat/o_max_lat are 0.
module packet_sink
    import router_pkg::*;
#(
    parameter int           BODY_COUNT  = 2,
    parameter ROUTER_CONFIG router_conf = '{default: 9999},
    parameter int           TIMEOUT     = 64,
    parameter int           CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  FLIT_t                 i_flit,
    input  logic                  i_rec_req,
    output logic                  o_rec_ack,
    output logic                  o_pkt_done,
    output logic [CNT_W-1:0]      o_pkt_count,
    output logic [CNT_W-1:0]      o_err_count,
    output logic [2:0]            o_err_code,
    output logic [TAIL_TAG_W-1:0] o_last_lat,
    output logic [TAIL_TAG_W-1:0] o_max_lat,
    output logic                  o_busy
);

    localparam int BC_W = $clog2(BODY_COUNT + 2);
    localparam int TO_W = $clog2(TIMEOUT + 2);
    localparam logic [BC_W-1:0] BODY_MAX = BC_W'(BODY_COUNT);
    localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT);

    SINK_STATE_t     state;
    SINK_ERR_t       err;
    logic [BC_W-1:0] body_cnt;
    logic [TO_W-1:0] to_cnt;

    logic       flit_vld;
    FLIT_TYPE_t ftype;
    logic       addr_ok;
    logic       unused_flit_bits;

    assign flit_vld = i_flit.flit[FLIT_SIZE-1];
    assign ftype    = flit_type(i_flit);
    assign addr_ok  = (i_flit.flit[XADDR_LSB +: ADDR_W] == router_conf.xaddr[ADDR_W-1:0]) &&
                      (i_flit.flit[YADDR_LSB +: ADDR_W] == router_conf.yaddr[ADDR_W-1:0]);
    assign unused_flit_bits = ^i_flit.flit[FT_LSB-1:XADDR_LSB+ADDR_W];
    assign o_busy   = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            err         <= '0;
            body_cnt    <= '0;
            to_cnt      <= '0;
            o_rec_ack   <= 1'b0;
            o_pkt_done  <= 1'b0;
            o_pkt_count <= '0;
            o_err_count <= '0;
            o_err_code  <= '0;
        end else begin
            o_pkt_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start && i_rec_req) begin
                        state     <= S_WAIT_HEAD;
                        o_rec_ack <= 1'b1;
                        err       <= '0;
                        body_cnt  <= '0;
                        to_cnt    <= '0;
                    end
                end
                S_WAIT_HEAD, S_RECV, S_DRAIN: begin
                    if (!flit_vld) begin
                        // TIMEOUT bubbles in a row are tolerated; the next one aborts the packet
                        if (to_cnt == TO_MAX) begin
                            err.timeout <= 1'b1;
                            state       <= S_DONE;
                            o_rec_ack   <= 1'b0;
                            o_pkt_done  <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end else begin
                        to_cnt <= '0;
                        if (state == S_WAIT_HEAD) begin
                            if (ftype == FT_HEAD) begin
                                if (!addr_ok)
                                    err.addr <= 1'b1;
                                body_cnt <= '0;
                                state    <= S_RECV;
                            end else begin
                                err.seq <= 1'b1;
                                state   <= S_DRAIN;
                            end
                        end else if (state == S_RECV) begin
                            case (ftype)
                                FT_BODY: begin
                                    if (body_cnt == BODY_MAX) begin
                                        err.seq <= 1'b1;
                                        state   <= S_DRAIN;
                                    end else begin
                                        body_cnt <= body_cnt + 1'b1;
                                    end
                                end
                                FT_TAIL: begin
                                    if (body_cnt != BODY_MAX)
                                        err.seq <= 1'b1;
                                    state      <= S_DONE;
                                    o_rec_ack  <= 1'b0;
                                    o_pkt_done <= 1'b1;
                                end
                                default: begin
                                    err.seq <= 1'b1;
                                    state   <= S_DRAIN;
                                end
                            endcase
                        end else if (ftype == FT_TAIL) begin
                            state      <= S_DONE;
                            o_rec_ack  <= 1'b0;
                            o_pkt_done <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (err == '0) begin
                        if (~&o_pkt_count)
                            o_pkt_count <= o_pkt_count + 1'b1;
                    end else begin
                        if (~&o_err_count)
                            o_err_count <= o_err_count + 1'b1;
                        o_err_code <= o_err_code | err;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state     <= S_IDLE;
                    o_rec_ack <= 1'b0;
                end
            endcase
        end
    end

`ifdef PKT_SINK_LAT_EN
    logic lat_load;
    logic lat_commit;

    assign lat_load   = (state == S_RECV) && flit_vld && (ftype == FT_TAIL);
    assign lat_commit = (state == S_DONE) && (err == '0);

    pkt_latency_tracker u_lat (
        .clk        (clk),
        .reset      (reset),
        .i_tag_vld  (lat_load),
        .i_tag      (i_flit.flit[TAIL_TAG_W-1:0]),
        .i_commit   (lat_commit),
        .o_last_lat (o_last_lat),
        .o_max_lat  (o_max_lat)
    );
`else
    assign o_last_lat = '0;
    assign o_max_lat  = '0;
`endif

endmodule

// File: tb/tb_packet_sink.sv
// Scoreboard bench for packet_sink at node (1,2), BODY_COUNT=2, TIMEOUT=8.
module tb_packet_sink;
    import router_pkg::*;

`ifdef PKT_SINK_LAT_EN
    localparam bit LAT_EN = 1'b1;
`else
    localparam bit LAT_EN = 1'b0;
`endif
    localparam int CNT_W = 32;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  i_start = 1'b0;
    logic                  i_rec_req = 1'b0;
    FLIT_t                 i_flit;
    logic                  o_rec_ack, o_pkt_done, o_busy;
    logic [CNT_W-1:0]      o_pkt_count, o_err_count;
    logic [2:0]            o_err_code;
    logic [TAIL_TAG_W-1:0] o_last_lat, o_max_lat;

    typedef struct {
        logic [2:0]  err;
        logic [15:0] lat;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    logic [15:0]      cyc;
    logic [CNT_W-1:0] exp_pkt = '0, exp_err = '0;
    logic [2:0]       exp_code = '0;
    logic [15:0]      exp_last = '0, exp_max = '0;

    packet_sink #(
        .BODY_COUNT  (2),
        .router_conf ('{xaddr: 1, yaddr: 2}),
        .TIMEOUT     (8),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_start     (i_start),
        .i_flit      (i_flit),
        .i_rec_req   (i_rec_req),
        .o_rec_ack   (o_rec_ack),
        .o_pkt_done  (o_pkt_done),
        .o_pkt_count (o_pkt_count),
        .o_err_count (o_err_count),
        .o_err_code  (o_err_code),
        .o_last_lat  (o_last_lat),
        .o_max_lat   (o_max_lat),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    // Reference cycle counter, same reset/increment rule as the sink's
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= '0;
        else       cyc <= cyc + 16'd1;
    end

    // Consumer side of the scoreboard: one entry per o_pkt_done pulse
    always @(negedge clk) begin
        exp_t e;
        if (!reset && o_pkt_done) begin
            done_seen++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: pending=0 at done pulse, required >=1");
            end else begin
                e = sb.pop_front();
                if (e.err == 3'b000) begin
                    exp_pkt++;
                    exp_last = e.lat;
                    if (e.lat > exp_max) exp_max = e.lat;
                end else begin
                    exp_err++;
                    exp_code |= e.err;
                end
            end
        end
    end

    function automatic FLIT_t mk(input FLIT_TYPE_t t, input logic [15:0] p);
        FLIT_t f;
        f.flit = '0;
        f.flit[FLIT_SIZE-1] = 1'b1;
        f.flit[FT_MSB:FT_LSB] = t;
        f.flit[15:0] = p;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input FLIT_t f);
        i_flit = f;
        tick();
    endtask

    task automatic open_pkt(input string name);
        int n = 0;
        i_rec_req = 1'b1;
        while (o_rec_ack !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        i_rec_req = 1'b0;
        checks++;
        if (o_rec_ack !== 1'b1) begin
            errors++;
            $display("FAIL %s_ack: o_rec_ack=%b required 1", name, o_rec_ack);
        end
    endtask

    task automatic wait_done(input string name);
        int start = done_seen;
        int n = 0;
        i_flit = '0;
        while (done_seen == start && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (done_seen == start) begin
            errors++;
            $display("FAIL %s_done: no o_pkt_done within %0d cycles, required one", name, n);
        end
    endtask

    // HEAD(x,y), nbody BODY flits, TAIL; tag is absolute or (cycle - tagv)
    task automatic send_pkt(input logic [7:0] x, input logic [7:0] y, input int nbody,
                            input bit abs_tag, input logic [15:0] tagv, input logic [2:0] exp_e);
        logic [15:0] tag;
        put(mk(FT_HEAD, {x, y}));
        for (int i = 0; i < nbody; i++) put(mk(FT_BODY, 16'(i)));
        tag = abs_tag ? tagv : cyc - tagv;
        sb.push_back('{err: exp_e, lat: cyc - tag});
        put(mk(FT_TAIL, tag));
    endtask

    task automatic test_reset();
        checks++;
        if (o_rec_ack !== 1'b0 || o_pkt_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ack/done/busy=%b%b%b required 000", o_rec_ack, o_pkt_done, o_busy);
        end
        checks++;
        if (o_pkt_count !== '0 || o_err_count !== '0 || o_err_code !== 3'b000) begin
            errors++;
            $display("FAIL reset_cnt: pkt=%0d err=%0d code=%b required 0 0 000", o_pkt_count, o_err_count, o_err_code);
        end
        checks++;
        if (o_last_lat !== 16'h0 || o_max_lat !== 16'h0) begin
            errors++;
            $display("FAIL reset_lat: last=%h max=%h required 0 0", o_last_lat, o_max_lat);
        end
    endtask

    task automatic test_good();
        open_pkt("good");
        send_pkt(8'd1, 8'd2, 2, 1'b0, 16'd10, 3'b000);
        wait_done("good");
        checks++;
        if (o_pkt_count !== 32'd1 || o_err_count !== 32'd0) begin
            errors++;
            $display("FAIL good_cnt: pkt=%0d err=%0d required 1 0", o_pkt_count, o_err_count);
        end
        checks++;
        if (o_last_lat !== (LAT_EN ? 16'd10 : 16'd0)) begin
            errors++;
            $display("FAIL good_lat: last=%0d required %0d", o_last_lat, LAT_EN ? 10 : 0);
        end
        checks++;
        if (o_pkt_done !== 1'b0 || o_busy !== 1'b0 || done_seen !== 1) begin
            errors++;
            $display("FAIL good_pulse: done=%b busy=%b pulses=%0d required 0 0 1", o_pkt_done, o_busy, done_seen);
        end
    endtask

    task automatic test_addr();
        open_pkt("addr");
        send_pkt(8'd3, 8'd3, 2, 1'b0, 16'd7, 3'b001);
        wait_done("addr");
        checks++;
        if (o_err_count !== 32'd1 || o_err_code !== 3'b001 || o_pkt_count !== exp_pkt) begin
            errors++;
            $display("FAIL addr_err: err=%0d code=%b pkt=%0d required 1 001 %0d", o_err_count, o_err_code, o_pkt_count, exp_pkt);
        end
        checks++;
        if (o_last_lat !== (LAT_EN ? 16'd10 : 16'd0)) begin
            errors++;
            $display("FAIL addr_lat: last=%0d required unchanged %0d", o_last_lat, LAT_EN ? 10 : 0);
        end
    endtask

    task automatic test_length();
        open_pkt("short");
        send_pkt(8'd1, 8'd2, 1, 1'b0, 16'd3, 3'b010);
        wait_done("short");
        checks++;
        if (o_err_count !== 32'd2 || o_err_code !== 3'b011) begin
            errors++;
            $display("FAIL short_err: err=%0d code=%b required 2 011", o_err_count, o_err_code);
        end
        // Third BODY overflows BODY_COUNT: sink must drain until the TAIL
        open_pkt("long");
        put(mk(FT_HEAD, 16'h0102));
        for (int i = 0; i < 3; i++) put(mk(FT_BODY, 16'(i)));
        put(mk(FT_HEAD, 16'h0102));
        checks++;
        if (o_busy !== 1'b1 || o_rec_ack !== 1'b1 || o_pkt_done !== 1'b0) begin
            errors++;
            $display("FAIL long_drain: busy=%b ack=%b done=%b required 1 1 0", o_busy, o_rec_ack, o_pkt_done);
        end
        sb.push_back('{err: 3'b010, lat: 16'd0});
        put(mk(FT_TAIL, 16'h0));
        wait_done("long");
        checks++;
        if (o_err_count !== 32'd3 || o_err_code !== exp_code || o_pkt_count !== exp_pkt) begin
            errors++;
            $display("FAIL long_err: err=%0d code=%b pkt=%0d required 3 %b %0d", o_err_count, o_err_code, o_pkt_count, exp_code, exp_pkt);
        end
    endtask

    task automatic test_timeout();
        int start;
        int n = 0;
        open_pkt("tmo");
        put(mk(FT_HEAD, 16'h0102));
        sb.push_back('{err: 3'b100, lat: 16'd0});
        start = done_seen;
        i_flit = '0;
        while (done_seen == start && n < 40) begin
            tick();
            n++;
        end
        // 9th bubble fires; its DONE cycle ends one edge later
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL tmo_cycles: done seen after %0d bubbles, required 10", n);
        end
        checks++;
        if (o_err_code !== 3'b111 || o_err_count !== exp_err || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_err: code=%b err=%0d busy=%b required 111 %0d 0", o_err_code, o_err_count, o_busy, exp_err);
        end
        // Exactly TIMEOUT bubbles inside a packet are tolerated
        open_pkt("tol");
        put(mk(FT_HEAD, 16'h0102));
        put(mk(FT_BODY, 16'h0));
        i_flit = '0;
        repeat (8) tick();
        put(mk(FT_BODY, 16'h1));
        sb.push_back('{err: 3'b000, lat: cyc - (cyc - 16'd5)});
        put(mk(FT_TAIL, cyc - 16'd5));
        wait_done("tol");
        checks++;
        if (o_pkt_count !== 32'd2 || o_err_count !== 32'd4) begin
            errors++;
            $display("FAIL tol_cnt: pkt=%0d err=%0d required 2 4", o_pkt_count, o_err_count);
        end
    endtask

    task automatic test_start_gate();
        i_start = 1'b0;
        i_rec_req = 1'b1;
        repeat (4) tick();
        checks++;
        if (o_rec_ack !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL gate_idle: ack=%b busy=%b required 0 0", o_rec_ack, o_busy);
        end
        i_start = 1'b1;
        open_pkt("gate");
        put(mk(FT_HEAD, 16'h0102));
        i_start = 1'b0;
        put(mk(FT_BODY, 16'h0));
        put(mk(FT_BODY, 16'h1));
        sb.push_back('{err: 3'b000, lat: 16'd2});
        put(mk(FT_TAIL, cyc - 16'd2));
        wait_done("gate");
        checks++;
        if (o_pkt_count !== exp_pkt || o_pkt_count !== 32'd3) begin
            errors++;
            $display("FAIL gate_cnt: pkt=%0d required 3", o_pkt_count);
        end
        i_start = 1'b1;
    endtask

    task automatic test_wrap_max();
        logic [15:0] wrap_lat;
        open_pkt("wrap");
        wrap_lat = cyc + 16'd3 - 16'hFFF0;
        send_pkt(8'd1, 8'd2, 2, 1'b1, 16'hFFF0, 3'b000);
        wait_done("wrap");
        checks++;
        if (o_last_lat !== (LAT_EN ? wrap_lat : 16'd0) || o_max_lat !== (LAT_EN ? wrap_lat : 16'd0)) begin
            errors++;
            $display("FAIL wrap_lat: last=%h max=%h required %h", o_last_lat, o_max_lat, LAT_EN ? wrap_lat : 16'd0);
        end
        open_pkt("small");
        send_pkt(8'd1, 8'd2, 2, 1'b0, 16'd4, 3'b000);
        wait_done("small");
        checks++;
        if (o_last_lat !== (LAT_EN ? 16'd4 : 16'd0) || o_max_lat !== (LAT_EN ? exp_max : 16'd0)) begin
            errors++;
            $display("FAIL max_hold: last=%h max=%h required %h %h", o_last_lat, o_max_lat, LAT_EN ? 16'd4 : 16'd0, LAT_EN ? exp_max : 16'd0);
        end
    endtask

    task automatic test_reset_mid();
        open_pkt("rst");
        put(mk(FT_HEAD, 16'h0102));
        put(mk(FT_BODY, 16'h0));
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (o_rec_ack !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_ctrl: ack=%b busy=%b required 0 0", o_rec_ack, o_busy);
        end
        checks++;
        if (o_pkt_count !== '0 || o_err_count !== '0 || o_max_lat !== 16'h0) begin
            errors++;
            $display("FAIL rst_cnt: pkt=%0d err=%0d max=%h required 0 0 0", o_pkt_count, o_err_count, o_max_lat);
        end
        exp_pkt = '0; exp_err = '0; exp_code = '0; exp_last = '0; exp_max = '0;
        sb.delete();
        i_flit = '0;
        tick();
        reset = 1'b0;
        tick();
        open_pkt("post");
        send_pkt(8'd1, 8'd2, 2, 1'b0, 16'd6, 3'b000);
        wait_done("post");
        checks++;
        if (o_pkt_count !== 32'd1 || o_err_count !== 32'd0 || o_last_lat !== (LAT_EN ? 16'd6 : 16'd0)) begin
            errors++;
            $display("FAIL post_rst: pkt=%0d err=%0d last=%0d required 1 0 %0d", o_pkt_count, o_err_count, o_last_lat, LAT_EN ? 6 : 0);
        end
    endtask

    initial begin
        i_flit = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        i_start = 1'b1;
        tick();
        test_reset();
        test_good();
        test_addr();
        test_length();
        test_timeout();
        test_start_gate();
        test_wrap_max();
        test_reset_mid();
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
